// File: rtl/door_motor_driver.sv
// door_motor_driver
// Actuator end of the garage door power interface. Turns the controller's
// power_up/power_down requests into a dead-time-protected, soft-started PWM
// drive on two motor outputs, trips on an obstruction while lowering, and
// tracks door position to report the end-stop flags back.
module door_motor_driver #(
   parameter int TRAVEL      = 100,
   parameter int POS_RESET   = 50,
   parameter int POS_W       = 7,
   parameter int PWM_PERIOD  = 8,
   parameter int DEAD_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic power_up,
   input  logic power_down,
   input  logic obstruction,
   output logic motor_up,
   output logic motor_down,
   output logic door_up,
   output logic door_down,
   output logic fault
);

   localparam int PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
   localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

   localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(TRAVEL);
   localparam logic [POS_W-1:0]  POS_INIT  = POS_W'(POS_RESET);
   localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
   localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
   localparam logic [PWM_W-1:0]  PWM_ONE   = PWM_W'(1);
   localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_PERIOD);
   localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DEAD   = 3'd1,
      S_RUN_UP = 3'd2,
      S_RUN_DN = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   state_t             state_q,    state_d;
   logic [POS_W-1:0]   pos_q,      pos_d;
   logic [PWM_W-1:0]   pwm_cnt_q,  pwm_cnt_d;
   logic [DUTY_W-1:0]  duty_q,     duty_d;
   logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
   logic               dir_up_q,   dir_up_d;

   logic cmd_up;
   logic cmd_dn;
   logic cmd_dir;
   logic pwm_on;

   // Conflicting or absent requests both mean "no command".
   assign cmd_up  = power_up & ~power_down;
   assign cmd_dn  = power_down & ~power_up;
   assign cmd_dir = dir_up_q ? cmd_up : cmd_dn;

   // State and datapath registers; reset restores the parked position.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pos_q      <= POS_INIT;
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
         dead_cnt_q <= '0;
         dir_up_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
         dead_cnt_q <= dead_cnt_d;
         dir_up_q   <= dir_up_d;
      end
   end

   // Next-state logic: dead-time sequencing, PWM ramp and position tracking.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      pwm_cnt_d  = pwm_cnt_q;
      duty_d     = duty_q;
      dead_cnt_d = dead_cnt_q;
      dir_up_d   = dir_up_q;
      unique case (state_q)
         S_IDLE: begin
            duty_d    = '0;
            pwm_cnt_d = '0;
            if (cmd_up && (pos_q != POS_TOP)) begin
               state_d    = S_DEAD;
               dir_up_d   = 1'b1;
               dead_cnt_d = '0;
            end else if (cmd_dn && (pos_q != '0) && !obstruction) begin
               state_d    = S_DEAD;
               dir_up_d   = 1'b0;
               dead_cnt_d = '0;
            end
         end
         S_DEAD: begin
            if (!cmd_dir) begin
               state_d = S_IDLE;
            end else if (dead_cnt_q == DEAD_LAST) begin
               state_d   = dir_up_q ? S_RUN_UP : S_RUN_DN;
               pwm_cnt_d = '0;
               duty_d    = DUTY_ONE;
            end else begin
               dead_cnt_d = dead_cnt_q + DEAD_ONE;
            end
         end
         S_RUN_UP: begin
            if (!cmd_up) begin
               state_d = S_IDLE;
               duty_d  = '0;
            end else if (pwm_cnt_q == PWM_LAST) begin
               // One full PWM period equals one position step.
               pwm_cnt_d = '0;
               pos_d     = pos_q + POS_ONE;
               duty_d    = (duty_q == DUTY_FULL) ? DUTY_FULL : duty_q + DUTY_ONE;
               if ((pos_q + POS_ONE) == POS_TOP) begin
                  state_d = S_IDLE;
               end
            end else begin
               pwm_cnt_d = pwm_cnt_q + PWM_ONE;
            end
         end
         S_RUN_DN: begin
            // Obstruction while lowering outranks every other exit.
            if (obstruction) begin
               state_d = S_FAULT;
               duty_d  = '0;
            end else if (!cmd_dn) begin
               state_d = S_IDLE;
               duty_d  = '0;
            end else if (pwm_cnt_q == PWM_LAST) begin
               pwm_cnt_d = '0;
               pos_d     = pos_q - POS_ONE;
               duty_d    = (duty_q == DUTY_FULL) ? DUTY_FULL : duty_q + DUTY_ONE;
               if (pos_q == POS_ONE) begin
                  state_d = S_IDLE;
               end
            end else begin
               pwm_cnt_d = pwm_cnt_q + PWM_ONE;
            end
         end
         S_FAULT: begin
            duty_d = '0;
            if (!power_down && !obstruction) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: only a running state can drive, so both outputs are never high together.
   always_comb begin
      pwm_on     = DUTY_W'(pwm_cnt_q) < duty_q;
      motor_up   = (state_q == S_RUN_UP) && pwm_on;
      motor_down = (state_q == S_RUN_DN) && pwm_on;
      door_up    = (pos_q == POS_TOP);
      door_down  = (pos_q == '0);
      fault      = (state_q == S_FAULT);
   end

endmodule

// File: tb/tb_door_motor_driver.sv
// tb_door_motor_driver
// Scoreboarded bench: the stimulus process advances a behavioural door model
// each clock and queues the expected outputs; a monitor pops and compares.
module tb_door_motor_driver;

   localparam int TRAVEL    = 100;
   localparam int POS_RESET = 50;
   localparam int P         = 8;
   localparam int DEAD      = 4;

   localparam int M_IDLE  = 0;
   localparam int M_DEAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_FAULT = 3;

   logic clock = 1'b0;
   logic reset, power_up, power_down, obstruction;
   logic motor_up, motor_down, door_up, door_down, fault;

   typedef logic [4:0] exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model: phase of operation, direction (+1/-1), position, clocks spent
   // running and clocks spent in dead time.
   int m_mode, m_dir, m_pos, m_tick, m_dc;

   always #5 clock = ~clock;

   door_motor_driver dut (
      .clock       (clock),
      .reset       (reset),
      .power_up    (power_up),
      .power_down  (power_down),
      .obstruction (obstruction),
      .motor_up    (motor_up),
      .motor_down  (motor_down),
      .door_up     (door_up),
      .door_down   (door_down),
      .fault       (fault)
   );

   task model_step();
      int  want;
      bit  up, dn;
      up = power_up && !power_down;
      dn = power_down && !power_up;
      if (reset) begin
         m_mode = M_IDLE; m_pos = POS_RESET; m_tick = 0; m_dc = 0; m_dir = -1;
      end else begin
         want = (m_dir > 0) ? up : dn;
         case (m_mode)
            M_IDLE: begin
               if (up && m_pos != TRAVEL) begin
                  m_mode = M_DEAD; m_dir = 1; m_dc = 0;
               end else if (dn && m_pos != 0 && !obstruction) begin
                  m_mode = M_DEAD; m_dir = -1; m_dc = 0;
               end
            end
            M_DEAD: begin
               if (!want) m_mode = M_IDLE;
               else if (m_dc == DEAD - 1) begin
                  m_mode = M_RUN; m_tick = 0;
               end else m_dc++;
            end
            M_RUN: begin
               if (m_dir < 0 && obstruction) m_mode = M_FAULT;
               else if (!want) m_mode = M_IDLE;
               else begin
                  if (m_tick % P == P - 1) begin
                     m_pos = m_pos + m_dir;
                     if (m_pos == 0 || m_pos == TRAVEL) m_mode = M_IDLE;
                  end
                  m_tick++;
               end
            end
            default: begin
               if (!power_down && !obstruction) m_mode = M_IDLE;
            end
         endcase
      end
   endtask

   function exp_t model_out();
      int  duty;
      bit  on;
      duty = (m_tick / P + 1 > P) ? P : m_tick / P + 1;
      on   = (m_mode == M_RUN) && ((m_tick % P) < duty);
      return {on && m_dir > 0, on && m_dir < 0, m_pos == TRAVEL, m_pos == 0,
              m_mode == M_FAULT};
   endfunction

   task drive(input logic r, input logic pu, input logic pd, input logic ob);
      @(negedge clock);
      reset = r; power_up = pu; power_down = pd; obstruction = ob;
      model_step();
      exp_q.push_back(model_out());
   endtask

   task run(input int n, input logic r, input logic pu, input logic pd, input logic ob);
      repeat (n) drive(r, pu, pd, ob);
   endtask

   // Monitor: compare each clock's outputs against the queued expectation.
   initial begin
      exp_t e, act;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {motor_up, motor_down, door_up, door_down, fault};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL outputs t=%0t actual=%b required=%b (mu md du dd flt)",
                        $time, act, e);
            end
            n_checks++;
            if (motor_up === 1'b1 && motor_down === 1'b1) begin
               n_fail++;
               $display("FAIL exclusive_drive t=%0t actual=11 required=not both high", $time);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=still running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int len, sel;
      logic pu, pd;
      reset = 1'b1; power_up = 1'b0; power_down = 1'b0; obstruction = 1'b0;
      m_mode = M_IDLE; m_pos = POS_RESET; m_tick = 0; m_dc = 0; m_dir = -1;
      run(3, 1, 0, 0, 0);
      run(5, 0, 0, 0, 0);
      // Raise from the reset position all the way to the top stop.
      run(420, 0, 1, 0, 0);
      run(10, 0, 0, 0, 0);
      // Lower a while, raise 10 periods, then reverse.
      run(4 + 30 * P + 1, 0, 0, 1, 0);
      run(4 + 10 * P + 1, 0, 1, 0, 0);
      run(80, 0, 0, 1, 0);
      // Obstruction while lowering, fault held by power_down, then cleared.
      run(3, 0, 0, 1, 1);
      run(5, 0, 0, 1, 0);
      run(5, 0, 0, 0, 0);
      // Conflicting requests: no motion.
      run(100, 0, 1, 1, 0);
      // Raise to top, then keep requesting up.
      run(4 + 100 * P + 5, 0, 1, 0, 0);
      run(20, 0, 1, 0, 0);
      run(3, 0, 0, 0, 0);
      // Lower to bottom, then keep requesting down.
      run(4 + 100 * P + 5, 0, 0, 1, 0);
      run(20, 0, 0, 1, 0);
      run(3, 0, 0, 0, 0);
      // Reset in the middle of a run at pos 73.
      run(5 + 73 * P + 3, 0, 1, 0, 0);
      run(1, 1, 1, 0, 0);
      run(20, 0, 0, 0, 0);
      run(4 + 50 * P + 3, 0, 1, 0, 0);
      // Randomised command sequences with sparse obstruction and reset pulses.
      repeat (40) begin
         len = $urandom_range(1, 150);
         sel = $urandom_range(0, 5);
         pu  = (sel == 0 || sel == 1 || sel == 4);
         pd  = (sel == 2 || sel == 3 || sel == 4);
         for (int i = 0; i < len; i++) begin
            drive(($urandom_range(0, 399) == 0), pu, pd, ($urandom_range(0, 39) == 0));
         end
      end
      run(3, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
